// File: rtl/flit_switch_arbiter_pkg.sv
// Shared flit-format constants and types for the router output-stage arbiter.
package flit_switch_arbiter_pkg;

  localparam int unsigned FLIT_SIZE  = 32;
  localparam int unsigned HEADER_LEN = 2;
  localparam int unsigned CMP_LEN    = 4;
  localparam int unsigned CMP_POS    = FLIT_SIZE - HEADER_LEN - CMP_LEN;

  typedef enum logic [HEADER_LEN-1:0] {
    HEAD_FLIT   = 2'b00,
    BODY_FLIT   = 2'b01,
    TAIL_FLIT   = 2'b10,
    SINGLE_FLIT = 2'b11
  } flit_type_t;

  typedef enum logic {StIdle, StLocked} arb_state_t;

  // HEAD and SINGLE flits open a new packet and may compete for an idle output.
  function automatic logic is_open_type(flit_type_t t);
    return (t == HEAD_FLIT) || (t == SINGLE_FLIT);
  endfunction

endpackage

// File: rtl/flit_switch_arbiter_if.sv
// Request/grant bundle between N input slots and one output-port arbiter.
interface flit_switch_arbiter_if import flit_switch_arbiter_pkg::*; #(
  parameter int unsigned N       = 6,
  parameter int unsigned CREDITS = 8
);
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CntW = $clog2(CREDITS + 1);

  logic [N-1:0]            req_valid;
  logic [N*HEADER_LEN-1:0] req_hdr;
  logic [N*CMP_LEN-1:0]    req_prio;
  logic                    credit_return;
  logic [N-1:0]            grant;
  logic                    grant_valid;
  logic [IdxW-1:0]         grant_idx;
  logic                    locked;
  logic [CntW-1:0]         credits;
  logic                    err;

  modport master (
    output req_valid, req_hdr, req_prio, credit_return,
    input  grant, grant_valid, grant_idx, locked, credits, err
  );

  modport slave (
    input  req_valid, req_hdr, req_prio, credit_return,
    output grant, grant_valid, grant_idx, locked, credits, err
  );

endinterface

// File: rtl/flit_switch_arbiter_rr_priority_picker.sv
// Combinational argmax over N keys; ties go to the first valid slot at or above start.
module rr_priority_picker #(
  parameter int unsigned N    = 6,
  parameter int unsigned KeyW = 5,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]      valid,
  input  logic [N*KeyW-1:0] keys,
  input  logic [IdxW-1:0]   start,
  output logic [N-1:0]      winner,
  output logic              any
);

  logic [KeyW-1:0] best;
  logic [KeyW-1:0] key;
  int unsigned     idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    best   = '0;
    key    = '0;
    idx    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = int'(start) + k;
      if (idx >= N) idx = idx - N;
      key = keys[idx*KeyW +: KeyW];
      // Strict compare keeps the earliest slot in search order on ties.
      if (valid[idx] && (!any || key > best)) begin
        winner      = '0;
        winner[idx] = 1'b1;
        best        = key;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/flit_switch_arbiter.sv
// Per-output wormhole arbiter: priority/age/round-robin pick, packet lock, credit gating.
module flit_switch_arbiter import flit_switch_arbiter_pkg::*; #(
  parameter int unsigned N         = 6,
  parameter int unsigned CREDITS   = 8,
  parameter int unsigned AGE_LIMIT = 15
) (
  input logic                  clk,
  input logic                  rst,
  flit_switch_arbiter_if.slave bus
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CntW = $clog2(CREDITS + 1);
  localparam int unsigned KeyW = CMP_LEN + 1;
  localparam logic [7:0]      AgeMax    = AGE_LIMIT[7:0];
  localparam logic [CntW-1:0] CreditMax = CntW'(CREDITS);

  arb_state_t      state_q;
  logic [IdxW-1:0] owner_q;
  logic [IdxW-1:0] rr_q;
  logic [CntW-1:0] credits_q;
  logic [7:0]      age_q [N];
  logic            err_q;

  flit_type_t        hdr [N];
  flit_type_t        g_hdr;
  logic [N-1:0]      open_type;
  logic [N-1:0]      closed_type;
  logic [N*KeyW-1:0] keys;
  logic [N-1:0]      pick_win;
  logic              pick_any;
  logic [N-1:0]      grant;
  logic              grant_valid;
  logic [IdxW-1:0]   gidx;
  logic              proto_err;

  always_comb begin
    keys        = '0;
    open_type   = '0;
    closed_type = '0;
    for (int unsigned i = 0; i < N; i++) begin
      hdr[i]         = flit_type_t'(bus.req_hdr[i*HEADER_LEN +: HEADER_LEN]);
      open_type[i]   = bus.req_valid[i] && is_open_type(hdr[i]);
      closed_type[i] = bus.req_valid[i] && !is_open_type(hdr[i]);
      keys[i*KeyW +: KeyW] = {age_q[i] == AgeMax, bus.req_prio[i*CMP_LEN +: CMP_LEN]};
    end
  end

  rr_priority_picker #(
    .N    (N),
    .KeyW (KeyW)
  ) u_picker (
    .valid  (open_type),
    .keys   (keys),
    .start  (rr_q),
    .winner (pick_win),
    .any    (pick_any)
  );

  always_comb begin
    grant = '0;
    if (!rst && credits_q != '0) begin
      if (state_q == StIdle) begin
        if (pick_any) grant = pick_win;
      end else if (bus.req_valid[owner_q]) begin
        grant[owner_q] = 1'b1;
      end
    end
  end

  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) gidx = IdxW'(i);
    end
  end

  assign grant_valid = |grant;
  assign g_hdr       = hdr[gidx];

  // Stray BODY/TAIL on any non-owner slot, a new packet inside a locked one, or credit overflow.
  always_comb begin
    proto_err = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (closed_type[i] && !(state_q == StLocked && owner_q == IdxW'(i))) proto_err = 1'b1;
    end
    if (state_q == StLocked && grant_valid && is_open_type(g_hdr)) proto_err = 1'b1;
    if (bus.credit_return && !grant_valid && credits_q == CreditMax) proto_err = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= '0;
      rr_q      <= '0;
      credits_q <= CreditMax;
      err_q     <= 1'b0;
      for (int unsigned i = 0; i < N; i++) age_q[i] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_valid) begin
            rr_q <= (gidx == IdxW'(N - 1)) ? '0 : gidx + 1'b1;
            if (g_hdr == HEAD_FLIT) begin
              state_q <= StLocked;
              owner_q <= gidx;
            end
          end
        end
        StLocked: begin
          if (grant_valid && g_hdr == TAIL_FLIT) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      for (int unsigned i = 0; i < N; i++) begin
        if (grant[i]) begin
          age_q[i] <= '0;
        end else if (open_type[i] && age_q[i] != AgeMax) begin
          age_q[i] <= age_q[i] + 8'd1;
        end
      end

      if (grant_valid && !bus.credit_return) begin
        credits_q <= credits_q - 1'b1;
      end else if (!grant_valid && bus.credit_return && credits_q != CreditMax) begin
        credits_q <= credits_q + 1'b1;
      end

      if (proto_err) err_q <= 1'b1;
    end
  end

  assign bus.grant       = grant;
  assign bus.grant_valid = grant_valid;
  assign bus.grant_idx   = gidx;
  assign bus.locked      = (state_q == StLocked);
  assign bus.credits     = credits_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_flit_switch_arbiter.sv
// Directed scoreboard bench for flit_switch_arbiter (N=4, CREDITS=2, AGE_LIMIT=3).
module tb_flit_switch_arbiter;
  import flit_switch_arbiter_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned CR = 2;
  localparam int unsigned AL = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  flit_switch_arbiter_if #(.N(N), .CREDITS(CR)) bus ();

  flit_switch_arbiter #(
    .N         (N),
    .CREDITS   (CR),
    .AGE_LIMIT (AL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string tag;
    bit    gv;
    int    gi;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic set_slot(input int i, input bit v, input flit_type_t t, input int p);
    bus.req_valid[i]                           = v;
    bus.req_hdr[i*HEADER_LEN +: HEADER_LEN]    = t;
    bus.req_prio[i*CMP_LEN +: CMP_LEN]         = p[CMP_LEN-1:0];
  endtask

  task automatic clear_all();
    bus.req_valid = '0;
    bus.req_hdr   = '0;
    bus.req_prio  = '0;
  endtask

  // Expected grant is queued with the stimulus, then retired at the negedge of that cycle.
  task automatic step(input string tag, input bit gv, input int gi);
    exp_t e;
    sb.push_back('{tag, gv, gi});
    @(negedge clk);
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".gv"}, 32'(bus.grant_valid), 32'(e.gv));
      check({e.tag, ".grant"}, 32'(bus.grant), e.gv ? (32'd1 << e.gi) : 32'd0);
      check({e.tag, ".idx"}, 32'(bus.grant_idx), e.gv ? 32'(e.gi) : 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    rst               = 1'b1;
    bus.credit_return = 1'b0;
    clear_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst.locked", 32'(bus.locked), 32'd0);
    check("rst.credits", 32'(bus.credits), 32'd2);
    check("rst.err", 32'(bus.err), 32'd0);
    check("rst.gv", 32'(bus.grant_valid), 32'd0);

    // Priority pick with round-robin tie-break and aging of the low-priority slot.
    set_slot(0, 1'b1, SINGLE_FLIT, 2);
    set_slot(1, 1'b1, SINGLE_FLIT, 7);
    set_slot(2, 1'b1, SINGLE_FLIT, 7);
    set_slot(3, 1'b1, SINGLE_FLIT, 1);
    bus.credit_return = 1'b1;
    step("t1a", 1'b1, 1);
    set_slot(1, 1'b0, SINGLE_FLIT, 0);
    step("t1b", 1'b1, 2);
    set_slot(2, 1'b0, SINGLE_FLIT, 0);
    step("t1c", 1'b1, 0);
    set_slot(0, 1'b0, SINGLE_FLIT, 0);
    step("t1d", 1'b1, 3);
    clear_all();
    bus.credit_return = 1'b0;
    check("t1.credits", 32'(bus.credits), 32'd2);
    check("t1.err", 32'(bus.err), 32'd0);

    // Wormhole lock: slot 3 holds the output across HEAD/BODY/TAIL.
    bus.credit_return = 1'b1;
    set_slot(3, 1'b1, HEAD_FLIT, 0);
    step("t2head", 1'b1, 3);
    check("t2head.locked", 32'(bus.locked), 32'd1);
    set_slot(3, 1'b1, BODY_FLIT, 0);
    set_slot(0, 1'b1, SINGLE_FLIT, 15);
    step("t2body", 1'b1, 3);
    check("t2body.locked", 32'(bus.locked), 32'd1);
    set_slot(3, 1'b1, TAIL_FLIT, 0);
    step("t2tail", 1'b1, 3);
    check("t2tail.locked", 32'(bus.locked), 32'd0);
    set_slot(3, 1'b0, HEAD_FLIT, 0);
    step("t2s0", 1'b1, 0);
    clear_all();
    bus.credit_return = 1'b0;
    check("t2.credits", 32'(bus.credits), 32'd2);
    check("t2.err", 32'(bus.err), 32'd0);

    // Credit stall and one-cycle-delayed recovery after a credit return.
    set_slot(0, 1'b1, SINGLE_FLIT, 5);
    set_slot(1, 1'b1, SINGLE_FLIT, 5);
    set_slot(2, 1'b1, SINGLE_FLIT, 5);
    step("t3a", 1'b1, 1);
    check("t3a.credits", 32'(bus.credits), 32'd1);
    set_slot(1, 1'b0, SINGLE_FLIT, 0);
    step("t3b", 1'b1, 2);
    check("t3b.credits", 32'(bus.credits), 32'd0);
    set_slot(2, 1'b0, SINGLE_FLIT, 0);
    step("t3stall", 1'b0, 0);
    bus.credit_return = 1'b1;
    step("t3ret", 1'b0, 0);
    check("t3ret.credits", 32'(bus.credits), 32'd1);
    bus.credit_return = 1'b0;
    step("t3d", 1'b1, 0);
    check("t3d.credits", 32'(bus.credits), 32'd0);
    clear_all();
    bus.credit_return = 1'b1;
    step("t3r1", 1'b0, 0);
    step("t3r2", 1'b0, 0);
    bus.credit_return = 1'b0;
    check("t3.credits", 32'(bus.credits), 32'd2);
    check("t3.err", 32'(bus.err), 32'd0);

    // Starvation: slot 0 wins after three losses, then its age is back to zero.
    bus.credit_return = 1'b1;
    set_slot(0, 1'b1, SINGLE_FLIT, 0);
    set_slot(1, 1'b1, SINGLE_FLIT, 15);
    step("t4a", 1'b1, 1);
    step("t4b", 1'b1, 1);
    step("t4c", 1'b1, 1);
    step("t4starved", 1'b1, 0);
    step("t4agereset", 1'b1, 1);
    clear_all();
    bus.credit_return = 1'b0;
    check("t4.err", 32'(bus.err), 32'd0);

    // Credit return at full count is an error and is sticky.
    bus.credit_return = 1'b1;
    step("t5full", 1'b0, 0);
    bus.credit_return = 1'b0;
    check("t5full.err", 32'(bus.err), 32'd1);
    check("t5full.credits", 32'(bus.credits), 32'd2);
    step("t5hold", 1'b0, 0);
    check("t5hold.err", 32'(bus.err), 32'd1);

    // Reset in the middle of a packet drops the lock and restores credits.
    set_slot(2, 1'b1, HEAD_FLIT, 0);
    step("t6head", 1'b1, 2);
    check("t6head.locked", 32'(bus.locked), 32'd1);
    check("t6head.credits", 32'(bus.credits), 32'd1);
    set_slot(2, 1'b0, HEAD_FLIT, 0);
    set_slot(0, 1'b1, SINGLE_FLIT, 3);
    rst = 1'b1;
    step("t6rst", 1'b0, 0);
    rst = 1'b0;
    check("t6rst.locked", 32'(bus.locked), 32'd0);
    check("t6rst.credits", 32'(bus.credits), 32'd2);
    check("t6rst.err", 32'(bus.err), 32'd0);
    step("t6s0", 1'b1, 0);
    check("t6s0.credits", 32'(bus.credits), 32'd1);
    clear_all();

    // BODY on an unlocked slot is never granted and sets the sticky error.
    set_slot(1, 1'b1, BODY_FLIT, 9);
    step("t5body", 1'b0, 0);
    check("t5body.err", 32'(bus.err), 32'd1);
    clear_all();
    step("t5sticky", 1'b0, 0);
    check("t5sticky.err", 32'(bus.err), 32'd1);
    check("t5sticky.locked", 32'(bus.locked), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
